pipe_ctrl: RTL and testbench

Pipeline sequencer for pipeRV32N that generates the per-stage `enable` and `nop` controls for IF/ID/EX/MEM/WB. It handles four conditions:
- a frozen pipeline, when any stage is not done;
- load-use stalls, since EX can only forward its own registered `res`;
- branch-redirect squashing;
- error halt at WB.

It sits beside the five stages at core top level and replaces hard-wired `enable=1`/`nop=0` ties.

---
 rtl/pipe_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for pipeRV32N.
// Drives the per-stage enable/nop controls for IF/ID/EX/MEM/WB. It covers
// whole-pipe freeze, load-use stalls, taken-branch squashing and error halt.
// Optional macro PIPE_CTRL_PERF_EN adds the stall/flush performance counters.
// Without the macro, both counter outputs are tied to zero.

module pipe_ctrl #(
    parameter int FLUSH_DEPTH              = 2,
    parameter int STALL_CNT_WIDTH          = 16,
    parameter int CPU_REGISTER_INDEX_WIDTH = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                if_done,
    input  logic                                id_done,
    input  logic                                ex_done,
    input  logic                                mem_done,
    input  logic                                wb_done,
    input  logic                                ex_is_load,
    input  logic [CPU_REGISTER_INDEX_WIDTH-1:0] ex_dest,
    input  logic [CPU_REGISTER_INDEX_WIDTH-1:0] id_rs1,
    input  logic [CPU_REGISTER_INDEX_WIDTH-1:0] id_rs2,
    input  logic                                id_rs1_used,
    input  logic                                id_rs2_used,
    input  logic                                branch_taken,
    input  logic                                wb_error,
    input  logic                                resume,
    output logic                                if_enable,
    output logic                                id_enable,
    output logic                                ex_enable,
    output logic                                mem_enable,
    output logic                                wb_enable,
    output logic                                id_nop,
    output logic                                ex_nop,
    output logic                                mem_nop,
    output logic                                wb_nop,
    output logic                                pc_hold,
    output logic                                halted,
    output logic [STALL_CNT_WIDTH-1:0]          stall_count,
    output logic [STALL_CNT_WIDTH-1:0]          flush_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

    state_t     state;
    logic [2:0] flush_cnt;
    logic       adv;
    logic       hazard;

    // Whole-pipe advance condition and the load-use hazard against EX's registered result
    always_comb begin
        adv    = if_done & id_done & ex_done & mem_done & wb_done;
        hazard = ex_is_load & (ex_dest != '0) &
                 ((id_rs1_used & (id_rs1 == ex_dest)) |
                  (id_rs2_used & (id_rs2 == ex_dest)));
    end

    // Zero-latency control decode; the first matching condition wins
    always_comb begin
        if_enable  = 1'b1;
        id_enable  = 1'b1;
        ex_enable  = 1'b1;
        mem_enable = 1'b1;
        wb_enable  = 1'b1;
        id_nop     = 1'b0;
        ex_nop     = 1'b0;
        mem_nop    = 1'b0;
        wb_nop     = 1'b0;
        pc_hold    = 1'b0;
        if (reset) begin
            {if_enable, id_enable, ex_enable, mem_enable, wb_enable} = 5'b00000;
            {id_nop, ex_nop, mem_nop, wb_nop} = 4'b1111;
            pc_hold = 1'b1;
        end else if (!adv || state == HALT) begin
            {if_enable, id_enable, ex_enable, mem_enable, wb_enable} = 5'b00000;
            pc_hold = 1'b1;
        end else if (wb_error) begin
            id_nop  = 1'b1;
            ex_nop  = 1'b1;
            mem_nop = 1'b1;
            pc_hold = 1'b1;
        end else if (state == RUN && branch_taken) begin
            id_nop = 1'b1;
            ex_nop = 1'b1;
        end else if (state == RUN && hazard) begin
            if_enable = 1'b0;
            id_enable = 1'b0;
            pc_hold   = 1'b1;
            ex_nop    = 1'b1;
        end else if (state == FLUSH) begin
            id_nop = 1'b1;
        end
    end

    // Sequencer state, flush countdown and registered halted flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
            halted    <= 1'b0;
        end else if (adv) begin
            case (state)
                HALT: begin
                    if (resume) begin
                        state     <= RUN;
                        flush_cnt <= 3'd0;
                        halted    <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (wb_error) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                        if (flush_cnt <= 3'd1) begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    if (wb_error) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (branch_taken && FLUSH_DEPTH > 1) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic stall_inc;
    logic flush_inc;

    // Events that cost a cycle or trigger a branch flush
    always_comb begin
        stall_inc = !adv || (state == RUN && !wb_error && !branch_taken && hazard);
        flush_inc = adv && state == RUN && !wb_error && branch_taken;
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_inc && stall_count != '1) begin
                stall_count <= stall_count + STALL_CNT_WIDTH'(1);
            end
            if (flush_inc && flush_count != '1) begin
                flush_count <= flush_count + STALL_CNT_WIDTH'(1);
            end
        end
    end
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed, table-driven bench for pipe_ctrl (FLUSH_DEPTH=2,
// 4-bit counters so saturation is reachable quickly).

module tb_pipe_ctrl;

    localparam int W = 4;

    localparam logic [9:0] NORMAL  = 10'b11111_0000_0;
    localparam logic [9:0] FREEZE  = 10'b00000_0000_1;
    localparam logic [9:0] LOADUSE = 10'b00111_0100_1;
    localparam logic [9:0] RESETR  = 10'b00000_1111_1;
    localparam logic [9:0] BRANCH  = 10'b11111_1100_0;
    localparam logic [9:0] FLUSHR  = 10'b11111_1000_0;
    localparam logic [9:0] ERRROW  = 10'b11111_1110_1;
    localparam logic [9:0] HALTR   = 10'b00000_0000_1;

    logic clk = 1'b0;
    logic reset;
    logic if_done, id_done, ex_done, mem_done, wb_done;
    logic ex_is_load;
    logic [4:0] ex_dest, id_rs1, id_rs2;
    logic id_rs1_used, id_rs2_used;
    logic branch_taken, wb_error, resume;
    logic if_enable, id_enable, ex_enable, mem_enable, wb_enable;
    logic id_nop, ex_nop, mem_nop, wb_nop, pc_hold, halted;
    logic [W-1:0] stall_count, flush_count;
    logic [9:0] ctrl;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    typedef struct {
        string      name;
        logic [4:0] done;
        logic       is_load;
        logic [4:0] dest;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       res;
        logic [9:0] exp_ctrl;
        logic       stall;
    } vec_t;

    vec_t vecs[10];

    pipe_ctrl #(.FLUSH_DEPTH(2), .STALL_CNT_WIDTH(W), .CPU_REGISTER_INDEX_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .if_done(if_done), .id_done(id_done), .ex_done(ex_done),
        .mem_done(mem_done), .wb_done(wb_done),
        .ex_is_load(ex_is_load), .ex_dest(ex_dest),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .branch_taken(branch_taken), .wb_error(wb_error), .resume(resume),
        .if_enable(if_enable), .id_enable(id_enable), .ex_enable(ex_enable),
        .mem_enable(mem_enable), .wb_enable(wb_enable),
        .id_nop(id_nop), .ex_nop(ex_nop), .mem_nop(mem_nop), .wb_nop(wb_nop),
        .pc_hold(pc_hold), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign ctrl = {if_enable, id_enable, ex_enable, mem_enable, wb_enable,
                   id_nop, ex_nop, mem_nop, wb_nop, pc_hold};

    // Counter values the bench expects, honouring build option and saturation
    function automatic logic [W-1:0] expCount(input int n);
`ifdef PIPE_CTRL_PERF_EN
        return (n > (1 << W) - 1) ? W'((1 << W) - 1) : W'(n);
`else
        return W'(n - n);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkCounters(input string name);
        checkOutput({name, " stall_count"}, 16'(stall_count), 16'(expCount(exp_stall)));
        checkOutput({name, " flush_count"}, 16'(flush_count), 16'(expCount(exp_flush)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        {if_done, id_done, ex_done, mem_done, wb_done} = 5'b11111;
        ex_is_load   = 1'b0;
        ex_dest      = 5'd0;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_rs1_used  = 1'b0;
        id_rs2_used  = 1'b0;
        branch_taken = 1'b0;
        wb_error     = 1'b0;
        resume       = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        idleInputs();
        {if_done, id_done, ex_done, mem_done, wb_done} = v.done;
        ex_is_load  = v.is_load;
        ex_dest     = v.dest;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_rs1_used = v.use1;
        id_rs2_used = v.use2;
        resume      = v.res;
    endtask

    initial begin
        vecs[0] = '{"clean",        5'b11111, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORMAL,  1'b0};
        vecs[1] = '{"loaduse_rs1",  5'b11111, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, LOADUSE, 1'b1};
        vecs[2] = '{"dest_zero",    5'b11111, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, NORMAL,  1'b0};
        vecs[3] = '{"loaduse_rs2",  5'b11111, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b1, 1'b0, LOADUSE, 1'b1};
        vecs[4] = '{"rs2_unused",   5'b11111, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, NORMAL,  1'b0};
        vecs[5] = '{"not_load",     5'b11111, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, NORMAL,  1'b0};
        vecs[6] = '{"mem_freeze",   5'b11101, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FREEZE,  1'b1};
        vecs[7] = '{"freeze_haz",   5'b01111, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, FREEZE,  1'b1};
        vecs[8] = '{"wb_freeze",    5'b11110, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FREEZE,  1'b1};
        vecs[9] = '{"resume_run",   5'b11111, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, NORMAL,  1'b0};

        // Reset for two cycles, then a clean run
        idleInputs();
        reset = 1'b1;
        #2;
        checkOutput("reset ctrl", 16'(ctrl), 16'(RESETR));
        tick();
        tick();
        checkOutput("reset halted", 16'(halted), 16'd0);
        reset = 1'b0;
        tick();
        checkOutput("clean ctrl", 16'(ctrl), 16'(NORMAL));
        checkCounters("after reset");

        // Table of single-cycle RUN-state vectors
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, " ctrl"}, 16'(ctrl), 16'(vecs[i].exp_ctrl));
            tick();
            if (vecs[i].stall) exp_stall++;
            checkOutput({vecs[i].name, " halted"}, 16'(halted), 16'd0);
            checkCounters(vecs[i].name);
        end

        // Branch: squash cycle, one FLUSH cycle ignoring branch/hazard, then RUN
        idleInputs();
        branch_taken = 1'b1;
        #1;
        checkOutput("branch ctrl", 16'(ctrl), 16'(BRANCH));
        tick();
        exp_flush++;
        checkCounters("branch");
        ex_is_load = 1'b1; ex_dest = 5'd6; id_rs1 = 5'd6; id_rs1_used = 1'b1;
        #1;
        checkOutput("flush ctrl", 16'(ctrl), 16'(FLUSHR));
        tick();
        idleInputs();
        #1;
        checkOutput("post flush ctrl", 16'(ctrl), 16'(NORMAL));
        checkCounters("post flush");

        // Branch with a 3-cycle freeze inside FLUSH
        branch_taken = 1'b1;
        tick();
        exp_flush++;
        branch_taken = 1'b0;
        mem_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("flush freeze ctrl", 16'(ctrl), 16'(FREEZE));
            tick();
            exp_stall++;
        end
        mem_done = 1'b1;
        #1;
        checkOutput("flush resumed ctrl", 16'(ctrl), 16'(FLUSHR));
        tick();
        #1;
        checkOutput("flush done ctrl", 16'(ctrl), 16'(NORMAL));
        checkCounters("flush freeze");

        // Error with branch and hazard together: error row wins
        wb_error = 1'b1; branch_taken = 1'b1;
        ex_is_load = 1'b1; ex_dest = 5'd2; id_rs2 = 5'd2; id_rs2_used = 1'b1;
        #1;
        checkOutput("error ctrl", 16'(ctrl), 16'(ERRROW));
        tick();
        checkOutput("error halted", 16'(halted), 16'd1);
        checkCounters("error");
        idleInputs();
        wb_error = 1'b1;
        #1;
        checkOutput("halt ctrl", 16'(ctrl), 16'(HALTR));
        tick();
        checkOutput("halt ignores error", 16'(halted), 16'd1);
        idleInputs();
        resume = 1'b1;
        #1;
        checkOutput("resume ctrl", 16'(ctrl), 16'(HALTR));
        tick();
        resume = 1'b0;
        checkOutput("resume halted", 16'(halted), 16'd0);
        #1;
        checkOutput("after resume ctrl", 16'(ctrl), 16'(NORMAL));

        // Re-enter HALT and reset asynchronously mid-cycle
        wb_error = 1'b1;
        tick();
        wb_error = 1'b0;
        checkOutput("halt again", 16'(halted), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        checkOutput("async reset halted", 16'(halted), 16'd0);
        checkOutput("async reset ctrl", 16'(ctrl), 16'(RESETR));
        checkCounters("async reset");
        #3;
        reset = 1'b0;
        tick();
        checkOutput("post reset ctrl", 16'(ctrl), 16'(NORMAL));

        // Saturation of the 4-bit stall counter, then async clear
        ex_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_stall++;
        end
        checkCounters("saturate");
        ex_done = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        exp_stall = 0;
        checkCounters("sat reset");
        #2;
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
